clock_time_ctrl: RTL and testbench
==================================

# clock_time_ctrl

Timekeeping and time-set controller for the digital clock. Consumes the single-cycle button pulses produced by the button conditioning blocks, maintains a 24-hour hh:mm:ss count from a 1 Hz enable derived from the system clock, and provides a three-state mode machine for setting hours and minutes. Its outputs feed the display/BCD stage.

## Interface
- CLK_HZ, 50_000_000 — CLK cycles per second; sets the 1 Hz prescaler terminal count (CLK_HZ ≥ 2; benches use 4).
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- mode_pulse  input  1  one-cycle pulse; advances the mode FSM.
- inc_pulse  input  1  one-cycle pulse; increments the selected field in set modes.
- dec_pulse  input  1  one-cycle pulse; decrements the selected field in set modes.
- hours  output  5  0–23, registered.
- minutes  output  6  0–59, registered.
- seconds  output  6  0–59, registered.
- mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN; 3 never driven.
- sec_tick  output  1  registered one-cycle strobe in the cycle after seconds advances in RUN.

## Operation
- Prescaler: counter of width clog2(CLK_HZ), counts 0..CLK_HZ-1 in RUN only; terminal count produces internal tick and wraps to 0 on the same edge.
- In SET_HR/SET_MIN the prescaler is held at 0 and seconds are frozen.
- FSM transitions, on mode_pulse only: RUN→SET_HR→SET_MIN→RUN.
- On SET_MIN→RUN: seconds cleared to 0, prescaler restarts from 0 (first tick CLK_HZ cycles after the transition edge).
- RUN: on tick, seconds+1; 59→0 carries minutes+1; minutes 59→0 carries hours+1; hours 23→0. 23:59:59 + tick → 00:00:00. inc/dec ignored.
- SET_HR: inc → hours+1 mod 24 (23→0); dec → hours−1 mod 24 (0→23). Minutes/seconds untouched.
- SET_MIN: inc → minutes+1 mod 60 (59→0); dec → (0→59). No carry/borrow into hours.
- Priority in one cycle: mode_pulse wins; inc/dec in that cycle ignored. inc and dec together: both ignored, no change.
- Inputs are not edge-detected here: an input held high for k cycles counts as k events.
- Illegal mode encoding 3 (unreachable) recovers to RUN on next edge.
- Out-of-range field values are unreachable; no saturation logic beyond the stated wraps.

## Timing
- Reset (RST=0, async): hours=0, minutes=0, seconds=0, mode=0 (RUN), sec_tick=0, prescaler=0; takes effect immediately, independent of CLK. Release is synchronous to next rising edge.
- Reset mid-set-operation: all state lost, returns to RUN at 00:00:00.
- Pulse sampled at edge N → updated outputs visible after edge N (one-cycle latency, no combinational input→output paths).
- From reset release, first seconds increment occurs on edge CLK_HZ (prescaler reaches CLK_HZ-1 on edge CLK_HZ-1, tick applied on edge CLK_HZ... i.e. seconds=1 after exactly CLK_HZ edges).
- sec_tick high exactly one cycle per seconds increment, aligned to the cycle in which the new seconds value is first visible.
- Back-to-back pulses on consecutive cycles each take effect (no dead time).

## Test plan
- Reset/run (CLK_HZ=4): release RST, run 8 edges → seconds=2, sec_tick asserted twice, hours=minutes=0; assert RST low mid-cycle → all outputs 0 without a clock edge.
- Rollover: set 23:59 via SET_HR/SET_MIN, return to RUN, run 60·4 edges → seconds reaches 59 then 00:00:00 with single sec_tick at wrap.
- Set hours wrap: RUN→SET_HR, dec_pulse once from 0 → hours=23; inc_pulse ×2 → hours=1; minutes unchanged.
- Set minutes no carry: in SET_MIN at 59, inc_pulse → minutes=0, hours unchanged; dec_pulse → 59.
- Simultaneous events: mode_pulse+inc_pulse same cycle in SET_HR → mode=SET_MIN, hours unchanged; inc_pulse+dec_pulse same cycle → no change.
- Freeze/restart: enter SET_HR at seconds=37, wait 20 edges → seconds stays 37, no sec_tick; exit to RUN → seconds=0, next sec_tick exactly 4 edges later.

Source files
------------

// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if: button-pulse inputs and time/mode outputs of the
// timekeeping controller.
//   master: drives mode/inc/dec pulses, observes time, mode and sec_tick
//   slave : the controller; consumes the pulses, drives the time outputs
interface clock_time_ctrl_if;
    logic       mode_pulse;
    logic       inc_pulse;
    logic       dec_pulse;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       sec_tick;

    modport master (
        output mode_pulse, inc_pulse, dec_pulse,
        input  hours, minutes, seconds, mode, sec_tick
    );

    modport slave (
        input  mode_pulse, inc_pulse, dec_pulse,
        output hours, minutes, seconds, mode, sec_tick
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 24-hour hh:mm:ss timekeeper with a RUN / SET_HR / SET_MIN
// mode machine for setting the time from single-cycle button pulses.
//   CLK   : system clock, all updates on the rising edge
//   RST   : asynchronous active-low reset
//   bus   : pulses in (mode/inc/dec), registered hours/minutes/seconds,
//           mode (0=RUN,1=SET_HR,2=SET_MIN) and sec_tick out
module clock_time_ctrl #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    clock_time_ctrl_if.slave  bus
);
    localparam int             PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PS_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    mode_t         state;
    logic [PW-1:0] presc;
    logic [4:0]    hours;
    logic [5:0]    minutes;
    logic [5:0]    seconds;
    logic          sec_tick;

    // inc and dec together cancel out
    logic inc, dec;
    assign inc = bus.inc_pulse & ~bus.dec_pulse;
    assign dec = bus.dec_pulse & ~bus.inc_pulse;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= RUN;
            presc    <= '0;
            hours    <= 5'd0;
            minutes  <= 6'd0;
            seconds  <= 6'd0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            case (state)
                RUN: begin
                    // Timekeeping keeps going on the edge that leaves RUN so
                    // a coincident tick is never lost.
                    if (presc == PS_MAX) begin
                        presc    <= '0;
                        sec_tick <= 1'b1;
                        if (seconds == 6'd59) begin
                            seconds <= 6'd0;
                            if (minutes == 6'd59) begin
                                minutes <= 6'd0;
                                hours   <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                            end else begin
                                minutes <= minutes + 6'd1;
                            end
                        end else begin
                            seconds <= seconds + 6'd1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (bus.mode_pulse) begin
                        state <= SET_HR;
                        presc <= '0;
                    end
                end
                SET_HR: begin
                    presc <= '0;
                    if (bus.mode_pulse)
                        state <= SET_MIN;
                    else if (inc)
                        hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
                    else if (dec)
                        hours <= (hours == 5'd0) ? 5'd23 : hours - 5'd1;
                end
                SET_MIN: begin
                    presc <= '0;
                    if (bus.mode_pulse) begin
                        // Back to RUN starts a fresh full second from :00
                        state   <= RUN;
                        seconds <= 6'd0;
                    end else if (inc)
                        minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
                    else if (dec)
                        minutes <= (minutes == 6'd0) ? 6'd59 : minutes - 6'd1;
                end
                default: begin
                    state <= RUN;
                    presc <= '0;
                end
            endcase
        end
    end

    assign bus.hours    = hours;
    assign bus.minutes  = minutes;
    assign bus.seconds  = seconds;
    assign bus.mode     = state;
    assign bus.sec_tick = sec_tick;
endmodule

// File: tb/tb_clock_time_ctrl.sv
module tb_clock_time_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(.CLK_HZ(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic m, i, d;
        int   h, mn, md;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // one-cycle pulse: raised at a negedge, sampled by the next posedge,
    // returns at the following negedge with the result visible
    task automatic pulse(input logic m, input logic i, input logic d);
        @(negedge CLK);
        bus.mode_pulse = m; bus.inc_pulse = i; bus.dec_pulse = d;
        @(negedge CLK);
        bus.mode_pulse = 1'b0; bus.inc_pulse = 1'b0; bus.dec_pulse = 1'b0;
    endtask

    task automatic do_reset();
        bus.mode_pulse = 1'b0; bus.inc_pulse = 1'b0; bus.dec_pulse = 1'b0;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    vec_t vt[14];
    int   ticks;

    initial begin
        vt[0]  = '{0,1,0,  0, 0,0};   // inc ignored in RUN
        vt[1]  = '{1,0,0,  0, 0,1};   // -> SET_HR
        vt[2]  = '{0,0,1, 23, 0,1};   // 0 -> 23
        vt[3]  = '{0,1,0,  0, 0,1};   // 23 -> 0
        vt[4]  = '{0,1,0,  1, 0,1};
        vt[5]  = '{0,1,1,  1, 0,1};   // inc+dec cancel
        vt[6]  = '{1,1,0,  1, 0,2};   // mode wins over inc
        vt[7]  = '{0,0,1,  1,59,2};   // 0 -> 59, no borrow
        vt[8]  = '{0,1,0,  1, 0,2};   // 59 -> 0, no carry
        vt[9]  = '{0,0,1,  1,59,2};
        vt[10] = '{0,1,1,  1,59,2};
        vt[11] = '{0,0,1,  1,58,2};
        vt[12] = '{1,0,1,  1,58,0};   // mode wins over dec -> RUN
        vt[13] = '{0,0,1,  1,58,0};   // dec ignored in RUN

        // reset state, checked while RST is still low
        bus.mode_pulse = 1'b0; bus.inc_pulse = 1'b0; bus.dec_pulse = 1'b0;
        #12;
        check("rst_hours", bus.hours, 0);
        check("rst_min",   bus.minutes, 0);
        check("rst_sec",   bus.seconds, 0);
        check("rst_mode",  bus.mode, 0);
        check("rst_tick",  bus.sec_tick, 0);

        // run 8 edges from release: two seconds, two ticks
        do_reset();
        ticks = 0;
        repeat (8) begin
            @(negedge CLK);
            if (bus.sec_tick) ticks++;
        end
        check("run_sec",   bus.seconds, 2);
        check("run_ticks", ticks, 2);
        check("run_hm",    bus.hours + bus.minutes, 0);
        // async reset mid-cycle, no clock edge needed
        #2 RST = 1'b0;
        #1;
        check("async_rst_sec", bus.seconds, 0);

        // reset in the middle of setting
        do_reset();
        pulse(1,0,0);
        pulse(0,1,0);
        check("set_hr_before_rst", bus.hours, 1);
        #2 RST = 1'b0;
        #1;
        check("midset_rst_mode",  bus.mode, 0);
        check("midset_rst_hours", bus.hours, 0);

        // table-driven set sequence
        do_reset();
        for (int k = 0; k < 14; k++) begin
            pulse(vt[k].m, vt[k].i, vt[k].d);
            check($sformatf("vec%0d_mode", k),  bus.mode,    vt[k].md);
            check($sformatf("vec%0d_hours", k), bus.hours,   vt[k].h);
            check($sformatf("vec%0d_min", k),   bus.minutes, vt[k].mn);
        end

        // rollover: set 23:59, back to RUN, 240 edges -> 00:00:00
        do_reset();
        pulse(1,0,0);
        pulse(0,0,1);
        pulse(1,0,0);
        pulse(0,0,1);
        pulse(1,0,0);
        check("roll_start_sec", bus.seconds, 0);
        ticks = 0;
        repeat (239) begin
            @(negedge CLK);
            if (bus.sec_tick) ticks++;
        end
        check("roll_sec59",  bus.seconds, 59);
        check("roll_hm",     bus.hours * 100 + bus.minutes, 2359);
        @(negedge CLK);
        if (bus.sec_tick) ticks++;
        check("roll_wrap_h", bus.hours, 0);
        check("roll_wrap_m", bus.minutes, 0);
        check("roll_wrap_s", bus.seconds, 0);
        check("roll_wrap_tick", bus.sec_tick, 1);
        check("roll_ticks", ticks, 60);
        @(negedge CLK);
        check("roll_tick_single", bus.sec_tick, 0);

        // freeze at 37 s in SET_HR, then restart from :00
        do_reset();
        repeat (148) @(negedge CLK);
        check("frz_sec37", bus.seconds, 37);
        pulse(1,0,0);
        ticks = 0;
        repeat (20) begin
            @(negedge CLK);
            if (bus.sec_tick) ticks++;
        end
        check("frz_sec_held", bus.seconds, 37);
        check("frz_no_tick",  ticks, 0);
        pulse(1,0,0);
        pulse(1,0,0);
        check("restart_mode", bus.mode, 0);
        check("restart_sec",  bus.seconds, 0);
        ticks = 0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.sec_tick) ticks++;
        end
        check("restart_early_tick", ticks, 0);
        @(negedge CLK);
        check("restart_tick4", bus.sec_tick, 1);
        check("restart_sec1",  bus.seconds, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
